// File: rtl/dout_packer.sv
// dout_packer: pairs consecutive DATA_WIDTH beats from a no-backpressure
// stream into 2*DATA_WIDTH words and queues them in a small FIFO for a
// valid/ready consumer. Words that find the FIFO full are dropped and
// raise a sticky overflow flag.
module dout_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int AW         = 2
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    din_valid,
  input  logic                    flush,
  output logic [2*DATA_WIDTH-1:0] pk_data,
  output logic                    pk_valid,
  input  logic                    pk_ready,
  output logic [AW:0]             level,
  output logic                    ovf_err,
  input  logic                    clr_err
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pack_state_t;

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  pack_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;
  logic [AW-1:0]           wptr_q, wptr_d;
  logic [AW-1:0]           rptr_q, rptr_d;
  logic [AW:0]             level_q, level_d;
  logic                    ovf_q, ovf_d;
  logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                    push_req;
  logic [2*DATA_WIDTH-1:0] push_word;
  logic                    pop;
  logic                    push_ok;

  // Pack FSM: decide whether this cycle completes a word and what it holds.
  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    push_req  = 1'b0;
    push_word = '0;
    unique case (state_q)
      ST_EMPTY: begin
        if (din_valid && flush) begin
          // A lone beat flushed immediately goes out zero-padded.
          push_req  = 1'b1;
          push_word = {{DATA_WIDTH{1'b0}}, din};
        end else if (din_valid) begin
          lo_d    = din;
          state_d = ST_HALF;
        end
      end
      ST_HALF: begin
        if (din_valid) begin
          // Completing beat wins; a coincident flush has nothing left to emit.
          push_req  = 1'b1;
          push_word = {din, lo_q};
          state_d   = ST_EMPTY;
        end else if (flush) begin
          push_req  = 1'b1;
          push_word = {{DATA_WIDTH{1'b0}}, lo_q};
          state_d   = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // FIFO bookkeeping: a full FIFO still accepts a push if it is popping too.
  always_comb begin
    pop     = (level_q != '0) && pk_ready;
    push_ok = push_req && ((level_q != FULL_LEVEL) || pop);
    wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push_ok && pop) begin
      level_d = level_q - 1'b1;
    end
    // Sticky overflow: a dropped word takes priority over a clear request.
    ovf_d = ovf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
    end
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  // State and pointer registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_EMPTY;
      lo_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge HCLK) begin
    if (HRESETn && push_ok) begin
      mem_q[wptr_q] <= push_word;
    end
  end

  assign pk_valid = (level_q != '0);
  assign pk_data  = (level_q != '0) ? mem_q[rptr_q] : '0;
  assign level    = level_q;
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_dout_packer.sv
// Directed bench for dout_packer: reset, pairing, flush, overflow,
// push+pop at full, mid-stream reset and clear/overflow priority.
module tb_dout_packer;

  logic        HCLK;
  logic        HRESETn;
  logic [15:0] din;
  logic        din_valid;
  logic        flush;
  logic [31:0] pk_data;
  logic        pk_valid;
  logic        pk_ready;
  logic [2:0]  level;
  logic        ovf_err;
  logic        clr_err;

  int total = 0;
  int bad   = 0;

  dout_packer #(.DATA_WIDTH(16), .DEPTH(4), .AW(2)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .din       (din),
    .din_valid (din_valid),
    .flush     (flush),
    .pk_data   (pk_data),
    .pk_valid  (pk_valid),
    .pk_ready  (pk_ready),
    .level     (level),
    .ovf_err   (ovf_err),
    .clr_err   (clr_err)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present one beat for one edge, then drop valid.
  task automatic beat(input logic [15:0] d);
    din       = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  initial begin
    HRESETn   = 1'b0;
    din       = 16'h1234;
    din_valid = 1'b1;
    flush     = 1'b1;
    pk_ready  = 1'b0;
    clr_err   = 1'b0;

    // 1: reset with live stimulus on the inputs
    tick();
    tick();
    check("rst_valid", {31'd0, pk_valid}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_ovf", {31'd0, ovf_err}, 32'd0);
    check("rst_data", pk_data, 32'd0);
    HRESETn   = 1'b1;
    din_valid = 1'b0;
    flush     = 1'b0;
    tick();
    check("rst_release_level", {29'd0, level}, 32'd0);

    // 2: basic pairing with a ready consumer
    pk_ready = 1'b1;
    beat(16'h1111);
    check("pack_half_novalid", {31'd0, pk_valid}, 32'd0);
    beat(16'h2222);
    check("pack_data", pk_data, 32'h2222_1111);
    check("pack_valid", {31'd0, pk_valid}, 32'd1);
    check("pack_level", {29'd0, level}, 32'd1);
    tick();
    check("pack_popped_valid", {31'd0, pk_valid}, 32'd0);
    check("pack_popped_level", {29'd0, level}, 32'd0);

    // 3: flush from HALF, flush in EMPTY, beat+flush together
    beat(16'hABCD);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_half_data", pk_data, 32'h0000_ABCD);
    check("flush_half_valid", {31'd0, pk_valid}, 32'd1);
    tick();
    check("flush_half_popped", {29'd0, level}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_empty_level", {29'd0, level}, 32'd0);
    check("flush_empty_valid", {31'd0, pk_valid}, 32'd0);
    din       = 16'h0005;
    din_valid = 1'b1;
    flush     = 1'b1;
    tick();
    din_valid = 1'b0;
    flush     = 1'b0;
    check("flush_beat_data", pk_data, 32'h0000_0005);
    check("flush_beat_level", {29'd0, level}, 32'd1);
    tick();
    check("flush_beat_popped", {29'd0, level}, 32'd0);

    // 4: fill and overflow with consumer stalled, then drain in order
    pk_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      beat(16'(i));
    end
    check("ovf_level", {29'd0, level}, 32'd4);
    check("ovf_flag", {31'd0, ovf_err}, 32'd1);
    check("ovf_head_stable", pk_data, 32'h0002_0001);
    pk_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d", k), pk_data, {16'(2*k+2), 16'(2*k+1)});
      tick();
    end
    pk_ready = 1'b0;
    check("drain_level", {29'd0, level}, 32'd0);
    check("drain_ovf_sticky", {31'd0, ovf_err}, 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_ovf", {31'd0, ovf_err}, 32'd0);

    // 5: completing pair while full and popping
    for (int i = 0; i < 8; i++) begin
      beat(16'h0011 + 16'(i));
    end
    check("full_level", {29'd0, level}, 32'd4);
    beat(16'h0021);
    din       = 16'h0022;
    din_valid = 1'b1;
    pk_ready  = 1'b1;
    tick();
    din_valid = 1'b0;
    pk_ready  = 1'b0;
    check("pushpop_level", {29'd0, level}, 32'd4);
    check("pushpop_ovf", {31'd0, ovf_err}, 32'd0);
    check("pushpop_head", pk_data, 32'h0014_0013);
    pk_ready = 1'b1;
    check("pushpop_d0", pk_data, 32'h0014_0013);
    tick();
    check("pushpop_d1", pk_data, 32'h0016_0015);
    tick();
    check("pushpop_d2", pk_data, 32'h0018_0017);
    tick();
    check("pushpop_tail", pk_data, 32'h0022_0021);
    tick();
    pk_ready = 1'b0;
    check("pushpop_empty", {29'd0, level}, 32'd0);

    // 6: reset mid-stream drops the queue and the held half-word
    beat(16'h0031);
    beat(16'h0032);
    beat(16'h0033);
    check("mid_level", {29'd0, level}, 32'd1);
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    check("mid_rst_level", {29'd0, level}, 32'd0);
    check("mid_rst_valid", {31'd0, pk_valid}, 32'd0);
    check("mid_rst_data", pk_data, 32'd0);
    beat(16'h0041);
    beat(16'h0042);
    check("fresh_pair", pk_data, 32'h0042_0041);
    check("fresh_level", {29'd0, level}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      beat(16'h0051 + 16'(i));
    end
    check("refill_level", {29'd0, level}, 32'd4);
    beat(16'h0057);
    din       = 16'h0058;
    din_valid = 1'b1;
    clr_err   = 1'b1;
    tick();
    din_valid = 1'b0;
    clr_err   = 1'b0;
    check("clr_vs_ovf", {31'd0, ovf_err}, 32'd1);
    check("clr_vs_ovf_level", {29'd0, level}, 32'd4);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_alone", {31'd0, ovf_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
